// File: rtl/seg_pattern_encoder.sv
// seg_pattern_encoder: turns a stream of active-low 7-segment glyphs back into
// hex nibbles and packs DIGITS of them into one word. The first digit accepted
// ends up in the most significant nibble. Any glyph that is not a legal hex
// digit is stored as 0 and sets an error flag that travels with its word.
module seg_pattern_encoder #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [6:0]            seg_in,
    input  logic                  seg_valid,
    output logic                  seg_ready,
    output logic [4*DIGITS-1:0]   word_out,
    output logic                  word_err,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic [3:0]            digit_cnt
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    localparam logic [3:0] LAST_DIGIT = 4'(DIGITS - 1);

    state_t              state;
    logic [4*DIGITS-1:0] shift_reg;
    logic [4*DIGITS-1:0] shift_next;
    logic                sticky_err;
    logic [3:0]          nibble;
    logic                legal;
    logic                accept;

    // Glyph lookup: segment bits are g..a, with 0 meaning the segment is lit.
    always_comb begin
        nibble = 4'h0;
        legal  = 1'b1;
        case (seg_in)
            7'b1000000: nibble = 4'h0;
            7'b1111001: nibble = 4'h1;
            7'b0100100: nibble = 4'h2;
            7'b0110000: nibble = 4'h3;
            7'b0011001: nibble = 4'h4;
            7'b0010010: nibble = 4'h5;
            7'b0000010: nibble = 4'h6;
            7'b1111000: nibble = 4'h7;
            7'b0000000: nibble = 4'h8;
            7'b0011000: nibble = 4'h9;
            7'b0001000: nibble = 4'hA;
            7'b0000011: nibble = 4'hB;
            7'b1000110: nibble = 4'hC;
            7'b0100001: nibble = 4'hD;
            7'b0000110: nibble = 4'hE;
            7'b0001110: nibble = 4'hF;
            default: begin
                nibble = 4'h0;
                legal  = 1'b0;
            end
        endcase
    end

    // Shift the partial word left by one digit and insert the new nibble at the bottom.
    always_comb begin
        shift_next       = shift_reg << 4;
        shift_next[3:0]  = nibble;
    end

    assign accept = seg_valid && seg_ready && (state == COLLECT);

    // Control FSM and all registered outputs; clear beats everything except reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= COLLECT;
            seg_ready  <= 1'b0;
            shift_reg  <= '0;
            sticky_err <= 1'b0;
            digit_cnt  <= 4'd0;
            word_out   <= '0;
            word_err   <= 1'b0;
            word_valid <= 1'b0;
        end else if (clear) begin
            state      <= COLLECT;
            seg_ready  <= 1'b1;
            shift_reg  <= '0;
            sticky_err <= 1'b0;
            digit_cnt  <= 4'd0;
            if (state == HOLD) begin
                word_out   <= '0;
                word_err   <= 1'b0;
                word_valid <= 1'b0;
            end
        end else begin
            case (state)
                COLLECT: begin
                    seg_ready <= 1'b1;
                    if (accept) begin
                        if (digit_cnt == LAST_DIGIT) begin
                            word_out   <= shift_next;
                            word_err   <= sticky_err | ~legal;
                            word_valid <= 1'b1;
                            state      <= HOLD;
                            seg_ready  <= 1'b0;
                            shift_reg  <= '0;
                            sticky_err <= 1'b0;
                            digit_cnt  <= 4'd0;
                        end else begin
                            shift_reg  <= shift_next;
                            sticky_err <= sticky_err | ~legal;
                            digit_cnt  <= digit_cnt + 4'd1;
                        end
                    end
                end
                HOLD: begin
                    if (word_valid && word_ready) begin
                        word_valid <= 1'b0;
                        state      <= COLLECT;
                        seg_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= COLLECT;
                    seg_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
